// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_buffer_ctrl
// Description : 64-cell (4 rows x 16 columns) character buffer for the text
//               engine. Serves registered per-character reads and sequences
//               writes decoded from the UART byte stream (printable codes,
//               CR, LF, BS, FF/clear and one-row scroll).
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               uartByteReady       - received byte valid (level, may be long)
//               uartDataIn[7:0]     - received byte
//               charAddress[5:0]    - engine read address {row[1:0], col[3:0]}
//               charOutput[7:0]     - registered buffer contents at charAddress
//               cursorPos[5:0]      - next write cell
//               busy                - clear or scroll sequence in progress
//               overrun             - sticky: a pending byte was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_ctrl #(
    parameter bit         SCROLL_EN  = 1'b1,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uartByteReady,
    input  logic [7:0] uartDataIn,
    input  logic [5:0] charAddress,
    output logic [7:0] charOutput,
    output logic [5:0] cursorPos,
    output logic       busy,
    output logic       overrun
);

    localparam logic [1:0] c_ST_CLEAR       = 2'd0;
    localparam logic [1:0] c_ST_IDLE        = 2'd1;
    localparam logic [1:0] c_ST_SCROLL_COPY = 2'd2;
    localparam logic [1:0] c_ST_SCROLL_FILL = 2'd3;

    localparam logic [7:0] c_CODE_BS = 8'h08;
    localparam logic [7:0] c_CODE_LF = 8'h0A;
    localparam logic [7:0] c_CODE_FF = 8'h0C;
    localparam logic [7:0] c_CODE_CR = 8'h0D;

    logic [1:0] r_state;
    logic [5:0] r_idx;
    logic       r_pending;
    logic       r_byteReadyD;
    logic [7:0] r_data;
    logic [7:0] r_mem [0:63];

    logic       w_edge;
    logic       w_consume;
    logic       w_printable;
    logic [1:0] w_row;
    logic [5:0] w_copySrc;
    logic       w_we;
    logic [5:0] w_waddr;
    logic [7:0] w_wdata;

    assign w_edge      = uartByteReady & ~r_byteReadyD;
    assign w_consume   = (r_state == c_ST_IDLE) & r_pending;
    assign w_printable = (r_data >= 8'h20) && (r_data <= 8'h7E);
    assign w_row       = cursorPos[5:4];
    assign w_copySrc   = r_idx + 6'd16;
    assign busy        = (r_state != c_ST_IDLE);

    // Single write port shared by the clear/scroll sequencers and the decoder.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_idx;
        w_wdata = BLANK_CHAR;
        case (r_state)
            c_ST_CLEAR:       w_we = 1'b1;
            c_ST_SCROLL_COPY: begin
                w_we    = 1'b1;
                w_wdata = r_mem[w_copySrc];
            end
            c_ST_SCROLL_FILL: w_we = 1'b1;
            default: begin
                if (w_consume) begin
                    if (w_printable) begin
                        w_we    = 1'b1;
                        w_waddr = cursorPos;
                        w_wdata = r_data;
                    end else if ((r_data == c_CODE_BS) && (cursorPos != 6'd0)) begin
                        w_we    = 1'b1;
                        w_waddr = cursorPos - 6'd1;
                    end
                end
            end
        endcase
    end

    // Buffer storage is deliberately not reset; the CLEAR sequence initialises it.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_CLEAR;
            r_idx        <= 6'd0;
            cursorPos    <= 6'd0;
            r_pending    <= 1'b0;
            r_byteReadyD <= 1'b0;
            r_data       <= 8'h00;
            overrun      <= 1'b0;
            charOutput   <= 8'h00;
        end else begin
            r_byteReadyD <= uartByteReady;
            // Read sees the pre-write contents when addresses collide.
            charOutput   <= r_mem[charAddress];

            // A new edge always wins over consumption; it is only an overrun
            // if the older byte is not being consumed on this same clock.
            if (w_edge) begin
                r_pending <= 1'b1;
                r_data    <= uartDataIn;
                if (r_pending && !w_consume) begin
                    overrun <= 1'b1;
                end
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                c_ST_CLEAR: begin
                    if (r_idx == 6'd63) begin
                        r_idx     <= 6'd0;
                        cursorPos <= 6'd0;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                c_ST_SCROLL_COPY: begin
                    if (r_idx == 6'd47) begin
                        r_state <= c_ST_SCROLL_FILL;
                    end
                    r_idx <= r_idx + 6'd1;
                end
                c_ST_SCROLL_FILL: begin
                    if (r_idx == 6'd63) begin
                        r_idx   <= 6'd0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                default: begin
                    if (w_consume) begin
                        if (w_printable) begin
                            if (cursorPos != 6'd63) begin
                                cursorPos <= cursorPos + 6'd1;
                            end else if (SCROLL_EN) begin
                                r_state   <= c_ST_SCROLL_COPY;
                                r_idx     <= 6'd0;
                                cursorPos <= 6'd48;
                            end else begin
                                cursorPos <= 6'd0;
                            end
                        end else begin
                            case (r_data)
                                c_CODE_LF: begin
                                    if (w_row != 2'd3) begin
                                        cursorPos <= {w_row + 2'd1, 4'd0};
                                    end else if (SCROLL_EN) begin
                                        r_state   <= c_ST_SCROLL_COPY;
                                        r_idx     <= 6'd0;
                                        cursorPos <= 6'd48;
                                    end else begin
                                        cursorPos <= 6'd0;
                                    end
                                end
                                c_CODE_CR: cursorPos <= {w_row, 4'd0};
                                c_CODE_BS: begin
                                    if (cursorPos != 6'd0) begin
                                        cursorPos <= cursorPos - 6'd1;
                                    end
                                end
                                c_CODE_FF: begin
                                    r_state <= c_ST_CLEAR;
                                    r_idx   <= 6'd0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_buffer_ctrl
// Description : Self-checking bench for text_buffer_ctrl. Two instances share
//               one byte stream: instance 0 scrolls, instance 1 wraps. A
//               behavioural screen model per instance predicts contents,
//               cursor, busy duration and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uartByteReady = 1'b0;
    logic [7:0] uartDataIn = 8'h00;
    logic [5:0] charAddress = 6'd0;

    logic [7:0] co0, co1;
    logic [5:0] cp0, cp1;
    logic       bz0, bz1;
    logic       ov0, ov1;

    int nCompared   = 0;
    int nMismatched = 0;

    // Screen model: one 64-cell screen, cursor and overrun flag per instance.
    logic [7:0] mdl [0:1][0:63];
    int         cur [0:1];
    bit         ovr [0:1];

    always #5 clk = ~clk;

    text_buffer_ctrl #(.SCROLL_EN(1'b1), .BLANK_CHAR(8'h20)) dut0 (
        .clk(clk), .rst(rst), .uartByteReady(uartByteReady), .uartDataIn(uartDataIn),
        .charAddress(charAddress), .charOutput(co0), .cursorPos(cp0), .busy(bz0), .overrun(ov0));

    text_buffer_ctrl #(.SCROLL_EN(1'b0), .BLANK_CHAR(8'h20)) dut1 (
        .clk(clk), .rst(rst), .uartByteReady(uartByteReady), .uartDataIn(uartDataIn),
        .charAddress(charAddress), .charOutput(co1), .cursorPos(cp1), .busy(bz1), .overrun(ov1));

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) mdl[k][a] = 8'h20;
            cur[k] = 0;
            ovr[k] = 1'b0;
        end
    endfunction

    // Screen moves up one row; bottom row blanked. Returns busy duration.
    function automatic int scrollOrWrap(input int k);
        if (k == 0) begin
            for (int a = 0; a < 48; a++) mdl[k][a] = mdl[k][a + 16];
            for (int a = 48; a < 64; a++) mdl[k][a] = 8'h20;
            cur[k] = 48;
            return 64;
        end
        cur[k] = 0;
        return 0;
    endfunction

    // Apply one consumed byte to the model; returns expected busy cycles.
    function automatic int modelApply(input int k, input logic [7:0] b);
        int row;
        row = cur[k] / 16;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mdl[k][cur[k]] = b;
            if (cur[k] < 63) cur[k] = cur[k] + 1;
            else return scrollOrWrap(k);
        end else if (b == 8'h0A) begin
            if (row < 3) cur[k] = (row + 1) * 16;
            else return scrollOrWrap(k);
        end else if (b == 8'h0D) begin
            cur[k] = row * 16;
        end else if (b == 8'h08) begin
            if (cur[k] > 0) begin
                cur[k] = cur[k] - 1;
                mdl[k][cur[k]] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            for (int a = 0; a < 64; a++) mdl[k][a] = 8'h20;
            cur[k] = 0;
            return 64;
        end
        return 0;
    endfunction

    task automatic checkResetValues(input string tag);
        nCompared += 8;
        if (co0 !== 8'h00 || co1 !== 8'h00) begin
            nMismatched++;
            $display("FAIL %s charOutput: got %h/%h want 00", tag, co0, co1);
        end
        if (cp0 !== 6'd0 || cp1 !== 6'd0) begin
            nMismatched++;
            $display("FAIL %s cursorPos: got %0d/%0d want 0", tag, cp0, cp1);
        end
        if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            nMismatched++;
            $display("FAIL %s busy: got %b/%b want 1", tag, bz0, bz1);
        end
        if (ov0 !== 1'b0 || ov1 !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s overrun: got %b/%b want 0", tag, ov0, ov1);
        end
    endtask

    // Release reset at a falling edge and measure the CLEAR busy window.
    task automatic releaseAndCount(input string tag);
        int b0, b1;
        rst = 1'b0;
        #1;
        b0 = bz0 ? 1 : 0;
        b1 = bz1 ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bz0) b0++;
            if (bz1) b1++;
        end
        modelReset();
        nCompared += 3;
        if (b0 != 64 || b1 != 64) begin
            nMismatched++;
            $display("FAIL %s busy cycles: got %0d/%0d want 64", tag, b0, b1);
        end
        if (cp0 !== 6'd0 || cp1 !== 6'd0) begin
            nMismatched++;
            $display("FAIL %s cursor after clear: got %0d/%0d want 0", tag, cp0, cp1);
        end
        if (bz0 !== 1'b0 || bz1 !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s busy after clear: got %b/%b want 0", tag, bz0, bz1);
        end
    endtask

    task automatic checkState(input string tag);
        nCompared += 4;
        if (cp0 !== 6'(cur[0])) begin
            nMismatched++;
            $display("FAIL %s cursor0: got %0d want %0d", tag, cp0, cur[0]);
        end
        if (cp1 !== 6'(cur[1])) begin
            nMismatched++;
            $display("FAIL %s cursor1: got %0d want %0d", tag, cp1, cur[1]);
        end
        if (ov0 !== ovr[0]) begin
            nMismatched++;
            $display("FAIL %s overrun0: got %b want %b", tag, ov0, ovr[0]);
        end
        if (ov1 !== ovr[1]) begin
            nMismatched++;
            $display("FAIL %s overrun1: got %b want %b", tag, ov1, ovr[1]);
        end
    endtask

    task automatic checkAll(input string tag);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            charAddress = 6'(a);
            @(negedge clk);
            nCompared += 2;
            if (co0 !== mdl[0][a]) begin
                nMismatched++;
                $display("FAIL %s mem0[%0d]: got %h want %h", tag, a, co0, mdl[0][a]);
            end
            if (co1 !== mdl[1][a]) begin
                nMismatched++;
                $display("FAIL %s mem1[%0d]: got %h want %h", tag, a, co1, mdl[1][a]);
            end
        end
    endtask

    // Present one byte with uartByteReady held for 'hold' cycles, count busy.
    task automatic sendByte(input logic [7:0] b, input int hold, input string tag);
        int e0, e1, c0, c1;
        @(negedge clk);
        uartDataIn    = b;
        uartByteReady = 1'b1;
        e0 = modelApply(0, b);
        e1 = modelApply(1, b);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < hold + 70; i++) begin
            @(negedge clk);
            if (bz0) c0++;
            if (bz1) c1++;
            if (i == hold - 1) uartByteReady = 1'b0;
        end
        nCompared += 2;
        if (c0 != e0) begin
            nMismatched++;
            $display("FAIL %s busy0 cycles byte %h: got %0d want %0d", tag, b, c0, e0);
        end
        if (c1 != e1) begin
            nMismatched++;
            $display("FAIL %s busy1 cycles byte %h: got %0d want %0d", tag, b, c1, e1);
        end
        checkState(tag);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        releaseAndCount("reset");
        checkState("reset");
        checkAll("reset");
    endtask

    task automatic test_hold_high();
        sendByte(8'h48, 100, "hold_H");
        sendByte(8'h69, 100, "hold_i");
        nCompared++;
        if (cp0 !== 6'd2) begin
            nMismatched++;
            $display("FAIL hold cursor: got %0d want 2", cp0);
        end
        checkAll("hold");
    endtask

    task automatic test_control();
        for (int i = 0; i < 3; i++) sendByte(8'($urandom_range(32, 126)), 2, "ctl_fill");
        sendByte(8'h41, 3, "ctl_A");
        sendByte(8'h0D, 3, "ctl_CR");
        sendByte(8'h0A, 3, "ctl_LF");
        sendByte(8'h08, 3, "ctl_BS");
        nCompared++;
        if (cp0 !== 6'd15) begin
            nMismatched++;
            $display("FAIL ctl cursor after BS: got %0d want 15", cp0);
        end
        checkAll("ctl");
    endtask

    task automatic test_random();
        logic [7:0] others [0:4];
        logic [7:0] b;
        int r;
        others[0] = 8'h00; others[1] = 8'h1B; others[2] = 8'h7F;
        others[3] = 8'hFF; others[4] = 8'h09;
        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      b = 8'($urandom_range(32, 126));
            else if (r == 6) b = 8'h0A;
            else if (r == 7) b = 8'h0D;
            else if (r == 8) b = 8'h08;
            else             b = others[$urandom_range(0, 4)];
            sendByte(b, $urandom_range(1, 6), "rand");
        end
        checkAll("rand");
    endtask

    task automatic test_scroll();
        sendByte(8'h0C, 2, "scr_FF");
        for (int a = 0; a < 63; a++) sendByte(8'(8'h41 + a / 16), 1, "scr_fill");
        sendByte(8'h45, 2, "scr_E");
        nCompared++;
        if (cp0 !== 6'd48 || cp1 !== 6'd0) begin
            nMismatched++;
            $display("FAIL scroll cursors: got %0d/%0d want 48/0", cp0, cp1);
        end
        checkAll("scroll");
    endtask

    task automatic test_overrun();
        logic [7:0] x, y;
        int waitCnt;
        x = 8'($urandom_range(32, 126));
        y = 8'($urandom_range(32, 126));
        @(negedge clk);
        uartDataIn = 8'h0C; uartByteReady = 1'b1;
        repeat (2) @(negedge clk);
        uartByteReady = 1'b0;
        repeat (10) @(negedge clk);
        uartDataIn = x; uartByteReady = 1'b1;
        repeat (2) @(negedge clk);
        uartByteReady = 1'b0;
        repeat (8) @(negedge clk);
        uartDataIn = y; uartByteReady = 1'b1;
        repeat (2) @(negedge clk);
        uartByteReady = 1'b0;
        waitCnt = 0;
        while ((bz0 || bz1) && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        repeat (4) @(negedge clk);
        nCompared++;
        if (waitCnt >= 200) begin
            nMismatched++;
            $display("FAIL overrun busy timeout: got busy %b/%b want 0", bz0, bz1);
        end
        for (int k = 0; k < 2; k++) begin
            void'(modelApply(k, 8'h0C));
            void'(modelApply(k, y));
            ovr[k] = 1'b1;
        end
        checkState("overrun");
        checkAll("overrun");
    endtask

    task automatic test_reset_mid_scroll();
        while (cur[0] < 48) sendByte(8'h0A, 2, "mid_LF");
        @(negedge clk);
        uartDataIn = 8'h0A; uartByteReady = 1'b1;
        repeat (2) @(negedge clk);
        uartByteReady = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetValues("midscroll");
        repeat (2) @(negedge clk);
        releaseAndCount("midscroll");
        checkState("midscroll");
        checkAll("midscroll");
    endtask

    initial begin
        modelReset();
        test_reset();
        test_hold_high();
        test_control();
        test_random();
        test_scroll();
        test_overrun();
        test_reset_mid_scroll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the 64-cell (4 rows x 16 columns) character buffer behind the text engine.
- Serves the engine's per-character reads and sequences writes from the UART byte stream: printable characters, cursor control codes, screen clear and one-row scroll.
- Sits between the uart receiver and the textEngine `charAddress`/`charOutput` interface in top.

Parameters:
- SCROLL_EN, 1: 1 = scroll up one row when text runs past row 3; 0 = wrap cursor to cell 0 with no scroll.
- BLANK_CHAR, 8'h20: code written by clear, scroll fill and backspace.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- uartByteReady  input  1  high while a received byte is valid; may stay high for many cycles
- uartDataIn  input  8  received byte
- charAddress  input  6  read address from text engine; [5:4] = row, [3:0] = column
- charOutput  output  8  buffer contents at `charAddress`, registered
- cursorPos  output  6  next write cell
- busy  output  1  high while in CLEAR, SCROLL_COPY or SCROLL_FILL
- overrun  output  1  sticky; a pending byte was overwritten before it was consumed

Behaviour:
- **Reset (async, rst=1):**
  - charOutput=8'h00, cursorPos=0, busy=1, overrun=0.
  - pending=0, byteReady_d=0, state=CLEAR, fill index=0.
  - Buffer array is not reset; CLEAR initialises it.
- **Read port:** charOutput <= mem[charAddress] every clock, 1-cycle latency, independent of state. A same-cycle write to the same cell returns the old value; the new value appears on the following read.
- **Byte capture:**
  - byteReady_d <= uartByteReady every clock.
  - On a clock where uartByteReady=1 and byteReady_d=0: pending<=1 and data<=uartDataIn. This happens in any state.
  - If pending is already 1 when a new edge arrives, the new byte replaces the old one and overrun<=1. overrun clears only on rst.
- **States:**
  - CLEAR:
    - Writes BLANK_CHAR to mem[idx] with idx = 0..63, one cell per cycle, 64 cycles.
    - Then cursorPos=0 and state goes to IDLE.
  - IDLE, pending=1: the byte is consumed on this clock (pending<=0), decoded as follows:
    - 0x20-0x7E: mem[cursorPos]<=data.
      - If cursorPos<63: cursorPos+1.
      - If cursorPos==63: SCROLL_EN ? (state<=SCROLL_COPY, cursorPos<=48) : cursorPos<=0.
    - 0x0A (LF): if row<3, cursorPos<={row+1,4'd0}. If row==3: SCROLL_EN ? (SCROLL_COPY, cursorPos<=48) : cursorPos<=0.
    - 0x0D (CR): cursorPos<={row,4'd0}.
    - 0x08 (BS): if cursorPos>0, cursorPos-1 and mem[cursorPos-1]<=BLANK_CHAR. At cursorPos==0, no effect.
    - 0x0C (FF): state<=CLEAR, idx<=0.
    - All other codes are discarded.
  - SCROLL_COPY: mem[idx]<=mem[idx+16] for idx = 0..47, one per cycle (48 cycles), then SCROLL_FILL.
  - SCROLL_FILL: mem[idx]<=BLANK_CHAR for idx = 48..63 (16 cycles), then IDLE.
- **Busy states:** in CLEAR and SCROLL_*, pending bytes are held, not consumed. Only one pending byte is retained; see overrun.
- **Latency:**
  - Byte edge sampled at clock N -> pending at N.
  - Consumed and written at N+1 if IDLE.
  - Visible on charOutput at N+2 when charAddress points at that cell.
- **Width rules:** cursorPos and idx are 6-bit. row = cursorPos[5:4]. No arithmetic wraps except the explicit rules above.
- **rst mid-CLEAR or mid-scroll:** restarts CLEAR from idx=0.

Test Plan:
- Reset release -> busy=1 for exactly 64 clocks, then busy=0 and cursorPos=0; all 64 reads return 8'h20.
- Bytes "H","i" with byteReady held high for 100 cycles each -> exactly one write per byte: mem[0]=8'h48, mem[1]=8'h69, cursorPos=2, overrun=0.
- 0x41 at cursorPos=5, then 0x0D, then 0x0A -> mem[5]=8'h41, cursorPos goes 6 -> 0 -> 16; 0x08 at cursorPos=16 -> cursorPos=15, mem[15]=8'h20.
- SCROLL_EN=1: fill rows with 'A','B','C','D', cursorPos=63, send 'E' -> busy high 64 cycles. Afterwards rows 0-2 = 'B','C','D' except cell 47='E', row 3 all 8'h20, cursorPos=48. Repeat with SCROLL_EN=0 -> no busy, cursorPos=0.
- Send 0x0C, then a byte edge at busy cycle 10, then a second edge at cycle 20 -> only the second byte is written at cell 0 after CLEAR; overrun=1.
- Assert rst during SCROLL_COPY idx=20 -> charOutput=0, cursorPos=0, busy=1, and a full 64-cycle CLEAR follows.
